window_fetch: RTL

- Reads KxK convolution windows out of the image memory through one of its read ports and streams the pixels to the DSP/filter stage over a valid/ready handshake.
- Sits directly downstream of the image memory read port B, which has 1-cycle registered read latency, and upstream of the MAC array.
- Stride 1, no padding ("valid" convolution), raster order over windows and over pixels within each window.

---
 rtl/window_fetch.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/window_fetch.sv
// Streams KxK stride-1 convolution windows from a 1-cycle-latency memory port
// to a valid/ready consumer, raster order over windows and pixels.
module window_fetch #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 18,
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int K      = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last_pix,
  output logic              out_last_win
);

  localparam int KW = $clog2(K + 1);
  localparam int XW = $clog2(IMG_W + 1);
  localparam int YW = $clog2(IMG_H + 1);
  localparam logic [KW-1:0] K_MAX  = KW'(K - 1);
  localparam logic [XW-1:0] OX_MAX = XW'(IMG_W - K);
  localparam logic [YW-1:0] OY_MAX = YW'(IMG_H - K);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last_pix;
    logic              last_win;
  } entry_t;

  state_t            state, next_state;
  logic              done_q;
  logic [ADDR_W-1:0] base_q;
  logic [KW-1:0]     kx, ky;
  logic [XW-1:0]     ox;
  logic [YW-1:0]     oy;
  logic              inflight, pipe_last_pix, pipe_last_win;
  entry_t            fifo [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        count;

  logic              pop, rd, is_last_pix, is_last_rd;
  logic [2:0]        pending;
  logic [ADDR_W-1:0] row, col;

  assign pop         = (count != 2'd0) && out_ready;
  assign is_last_pix = (kx == K_MAX) && (ky == K_MAX);
  assign is_last_rd  = is_last_pix && (ox == OX_MAX) && (oy == OY_MAX);
  // Entries that will exist next cycle before any new read: keeps the FIFO from overflowing.
  assign pending     = 3'(count) + 3'(inflight) - 3'(pop);
  assign rd          = (state == RUN) && (pending < 3'd2);
  assign row         = ADDR_W'(oy) + ADDR_W'(ky);
  assign col         = ADDR_W'(ox) + ADDR_W'(kx);

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      done_q <= 1'b0;
    end else begin
      state  <= next_state;
      done_q <= (state == DRAIN) && (next_state == IDLE);
    end
  end

  // NOTE: default assignment first so no path leaves next_state unassigned (no latch).
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (rd && is_last_rd) next_state = DRAIN;
      DRAIN:   if (pending == 3'd0) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state != IDLE);
    done         = done_q;
    mem_rd       = rd;
    mem_addr     = base_q + row * ADDR_W'(IMG_W) + col;
    out_valid    = (count != 2'd0);
    out_data     = fifo[rd_ptr].data;
    out_last_pix = fifo[rd_ptr].last_pix;
    out_last_win = fifo[rd_ptr].last_win;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q        <= '0;
      kx            <= '0;
      ky            <= '0;
      ox            <= '0;
      oy            <= '0;
      inflight      <= 1'b0;
      pipe_last_pix <= 1'b0;
      pipe_last_win <= 1'b0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      count         <= 2'd0;
      // NOTE: FIFO storage is reset too so out_data and flags read 0 straight out of reset.
      for (int i = 0; i < 2; i++) fifo[i] <= '0;
    end else begin
      if (state == IDLE && start) begin
        base_q <= base_addr;
        kx     <= '0;
        ky     <= '0;
        ox     <= '0;
        oy     <= '0;
      end else if (rd) begin
        if (kx == K_MAX) begin
          kx <= '0;
          if (ky == K_MAX) begin
            ky <= '0;
            if (ox == OX_MAX) begin
              ox <= '0;
              oy <= (oy == OY_MAX) ? '0 : oy + 1'b1;
            end else begin
              ox <= ox + 1'b1;
            end
          end else begin
            ky <= ky + 1'b1;
          end
        end else begin
          kx <= kx + 1'b1;
        end
      end

      // Flags travel one cycle behind the read so they meet the returning data.
      inflight <= rd;
      if (rd) begin
        pipe_last_pix <= is_last_pix;
        pipe_last_win <= is_last_rd;
      end

      if (inflight) begin
        fifo[wr_ptr] <= '{data: mem_data, last_pix: pipe_last_pix, last_win: pipe_last_win};
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= 2'(3'(count) + 3'(inflight) - 3'(pop));
    end
  end

endmodule
